// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown issuer and its downstream responder.
package countdown_pkg;

    localparam int unsigned DELAY_W     = 8;
    localparam int unsigned TABLE_DEPTH = 4;
    localparam int unsigned IDX_W       = $clog2(TABLE_DEPTH);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StIssue    = 3'd1;
    localparam logic [2:0] StWaitDone = 3'd2;
    localparam logic [2:0] StFinish   = 3'd3;
    localparam logic [2:0] StAbort    = 3'd4;

    typedef logic [DELAY_W-1:0] delay_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // Keeps a usable counter width even for degenerate timeouts of 1 or 2.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/countdown_issuer_timer.sv
// Saturating WAIT_DONE timeout counter; hit_o flags the last permitted cycle.
module countdown_issuer_timer
    import countdown_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 300
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic hit_o
);

    localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] HitVal = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != HitVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == HitVal);

endmodule

// File: rtl/countdown_issuer.sv
// Issues a programmable sequence of delay values to a countdown responder,
// waiting for each completion and aborting if one never arrives.
module countdown_issuer
    import countdown_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 300
) (
    input  logic               i_w_clk,
    input  logic               i_w_reset_n,
    input  logic               i_w_wr_en,
    input  logic [1:0]         i_w_wr_addr,
    input  logic [7:0]         i_w_wr_data,
    input  logic               i_w_start,
    input  logic [1:0]         i_w_last,
    input  logic               i_w_done,
    output logic               o_w_ready,
    output logic [7:0]         o_w_value,
    output logic               o_w_busy,
    output logic               o_w_finished,
    output logic               o_w_timeout
);

    logic [2:0] state_q, state_d;
    idx_t       idx_q, idx_d;
    idx_t       last_q, last_d;
    delay_t     tbl_q [TABLE_DEPTH];
    logic       tmr_clear, tmr_enable, tmr_hit;
    logic       in_idle;

    assign in_idle = (state_q == StIdle);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_w_start) begin
                    state_d = StIssue;
                    idx_d   = '0;
                    last_d  = i_w_last;
                end
            end
            StIssue: begin
                state_d   = StWaitDone;
                tmr_clear = 1'b1;
            end
            StWaitDone: begin
                // Completion takes priority over a coincident timeout hit.
                if (i_w_done) begin
                    if (idx_q == last_q) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StIssue;
                    end
                end else if (tmr_hit) begin
                    state_d = StAbort;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            StAbort:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (in_idle && i_w_wr_en) begin
            tbl_q[i_w_wr_addr] <= i_w_wr_data;
        end
    end

    countdown_issuer_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (i_w_clk),
        .rst_ni  (i_w_reset_n),
        .clear_i (tmr_clear),
        .enable_i(tmr_enable),
        .hit_o   (tmr_hit)
    );

    assign o_w_ready    = (state_q == StIssue);
    assign o_w_value    = o_w_ready ? tbl_q[idx_q] : '0;
    assign o_w_busy     = !in_idle;
    assign o_w_finished = (state_q == StFinish);
    assign o_w_timeout  = (state_q == StAbort);

endmodule

// File: tb/tb_countdown_issuer.sv
// Randomized self-checking bench for countdown_issuer against a transaction-level model.
module tb_countdown_issuer;

    localparam int T = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, start, done;
    logic [1:0] wr_addr, last;
    logic [7:0] wr_data, value;
    logic       ready, busy, finished, timeout;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mtbl [4];
    int         dly  [4];

    always #5 clk = ~clk;

    countdown_issuer #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_w_clk     (clk),
        .i_w_reset_n (rst_n),
        .i_w_wr_en   (wr_en),
        .i_w_wr_addr (wr_addr),
        .i_w_wr_data (wr_data),
        .i_w_start   (start),
        .i_w_last    (last),
        .i_w_done    (done),
        .o_w_ready   (ready),
        .o_w_value   (value),
        .o_w_busy    (busy),
        .o_w_finished(finished),
        .o_w_timeout (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input logic busy_exp);
        check_eq({tag, ".ready"}, 32'(ready), 32'(0));
        check_eq({tag, ".value"}, 32'(value), 32'(0));
        check_eq({tag, ".busy"}, 32'(busy), 32'(busy_exp));
        check_eq({tag, ".finished"}, 32'(finished), 32'(0));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(0));
    endtask

    task automatic clear_inputs();
        wr_en = 1'b0;
        start = 1'b0;
        done  = 1'b0;
    endtask

    // Junk traffic while busy: a table write and a restart, both to be dropped.
    task automatic drive_junk();
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 2'd1;
        wr_data = 8'hAA;
    endtask

    task automatic idle_write(input logic [1:0] a, input logic [7:0] d, input logic stray_done);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        done    = stray_done;
        mtbl[a] = d;
        tick();
        clear_inputs();
        check_quiet("idle_wr", 1'b0);
    endtask

    // One full sequence. dly[e] = WAIT_DONE cycle on which done arrives, -1 = never.
    task automatic run_seq(input logic [1:0] lst, input bit junk, input bit wr_same,
                           input logic [1:0] wa, input logic [7:0] wd, input int rst_at);
        bit aborted = 1'b0;
        check_eq("pre.busy", 32'(busy), 32'(0));
        start = 1'b1;
        last  = lst;
        if (wr_same) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
            mtbl[wa] = wd;
        end
        tick();
        clear_inputs();
        last = 2'($urandom);
        for (int e = 0; e <= int'(lst) && !aborted; e++) begin
            check_eq("issue.ready", 32'(ready), 32'(1));
            check_eq("issue.value", 32'(value), 32'(mtbl[e]));
            check_eq("issue.busy", 32'(busy), 32'(1));
            check_eq("issue.finished", 32'(finished), 32'(0));
            if (junk) begin
                drive_junk();
                done = 1'b1;
            end
            tick();
            clear_inputs();
            for (int k = 0; k <= T; k++) begin
                if (e == rst_at && k == 1) begin
                    #3 rst_n = 1'b0;
                    #1;
                    check_quiet("rst_mid", 1'b0);
                    mtbl = '{default: 8'h00};
                    return;
                end
                if (k == T) begin
                    check_eq("abort.timeout", 32'(timeout), 32'(1));
                    check_eq("abort.finished", 32'(finished), 32'(0));
                    check_eq("abort.ready", 32'(ready), 32'(0));
                    check_eq("abort.busy", 32'(busy), 32'(1));
                    aborted = 1'b1;
                    break;
                end
                check_quiet("wait", 1'b1);
                if (k == dly[e]) begin
                    done = 1'b1;
                    tick();
                    clear_inputs();
                    break;
                end
                if (junk) drive_junk();
                tick();
                clear_inputs();
            end
        end
        if (!aborted) begin
            check_eq("fin.finished", 32'(finished), 32'(1));
            check_eq("fin.timeout", 32'(timeout), 32'(0));
            check_eq("fin.ready", 32'(ready), 32'(0));
            check_eq("fin.busy", 32'(busy), 32'(1));
        end
        if (junk) begin
            drive_junk();
            done = 1'b1;
        end
        tick();
        clear_inputs();
        check_quiet("post", 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'd0;
        last    = 2'd0;
        clear_inputs();
        mtbl = '{default: 8'h00};
        #1;
        check_quiet("reset", 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_quiet("after_reset", 1'b0);

        // Four entries, responder answers 3 cycles after each ready.
        idle_write(2'd0, 8'd5, 1'b0);
        idle_write(2'd1, 8'd3, 1'b0);
        idle_write(2'd2, 8'd0, 1'b0);
        idle_write(2'd3, 8'd7, 1'b0);
        dly = '{2, 2, 2, 2};
        run_seq(2'd3, 1'b0, 1'b0, 2'd0, 8'd0, -1);

        // Single entry, done on the first wait cycle.
        idle_write(2'd0, 8'd9, 1'b1);
        dly = '{0, 0, 0, 0};
        run_seq(2'd0, 1'b0, 1'b0, 2'd0, 8'd0, -1);

        // Missing done aborts after T wait cycles.
        dly = '{-1, -1, -1, -1};
        run_seq(2'd1, 1'b0, 1'b0, 2'd0, 8'd0, -1);

        // Done on the timeout-hit cycle still progresses.
        dly = '{T - 1, T - 1, T - 1, T - 1};
        run_seq(2'd3, 1'b0, 1'b0, 2'd0, 8'd0, -1);

        // Writes and restarts while busy are dropped; rerun proves table intact.
        dly = '{1, 3, 0, 2};
        run_seq(2'd3, 1'b1, 1'b0, 2'd0, 8'd0, -1);
        run_seq(2'd3, 1'b0, 1'b0, 2'd0, 8'd0, -1);

        // Write together with start: first issue sees the new value.
        run_seq(2'd1, 1'b0, 1'b1, 2'd0, 8'h3C, -1);

        // Reset during WAIT_DONE of entry 2, then restart straight out of reset.
        dly = '{1, 1, 5, 1};
        run_seq(2'd3, 1'b0, 1'b0, 2'd0, 8'd0, 2);
        tick();
        check_quiet("in_reset", 1'b0);
        rst_n = 1'b1;
        dly = '{0, 1, 2, 3};
        run_seq(2'd3, 1'b0, 1'b0, 2'd0, 8'd0, -1);

        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                idle_write(2'($urandom), 8'($urandom), 1'($urandom));
            end
            for (int e = 0; e < 4; e++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      dly[e] = -1;
                else if (r == 1) dly[e] = T - 1;
                else if (r == 2) dly[e] = 0;
                else             dly[e] = int'($urandom_range(0, 6));
            end
            run_seq(2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
